// File: rtl/contador_param_if.sv
// rtl/contador_param_if.sv - read request/response bundle for contador_param
// Purpose: groups the read handshake of contador_param.
// Signals:
//   req      read request (driven by master)
//   idx      channel selected by req (driven by master)
//   valid    data_out holds a read result this cycle (driven by slave)
//   data_out counter value returned for the accepted req (driven by slave)
// Modports: master (requester side), slave (counter block side).
interface contador_param_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 5
);
  localparam int IDX_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  logic             req;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic [CNT_W-1:0] data_out;

  modport master (output req, output idx, input valid, input data_out);
  modport slave  (input req, input idx, output valid, output data_out);
endinterface

// File: rtl/contador_param.sv
// rtl/contador_param.sv - per-channel saturating event counters with gated 1-cycle read
// Purpose: keeps one CNT_W-bit saturating counter per channel, counts pop
//          strobes, and returns a counter value one cycle after a read is
//          accepted while the parent FSM sits in IDLE_ST.
// Ports:
//   clk      sole clock, rising edge
//   reset_L  asynchronous active-low reset
//   state    parent FSM state; reads honoured only when equal to IDLE_ST
//   pop      per-channel event strobe
//   clr      synchronous clear of all counters and ovf flags
//   ovf      sticky per-channel saturation flag
//   rd       read bundle (req, idx in; valid, data_out out)
// Optional feature: macro CONTADOR_CLR_ON_READ_EN makes accepted reads
//          destructive (selected counter and its ovf bit cleared on read).
module contador_param #(
  parameter int         NUM_CH  = 4,
  parameter int         CNT_W   = 5,
  parameter logic [3:0] IDLE_ST = 4'b0100
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        state,
  input  logic [NUM_CH-1:0] pop,
  input  logic              clr,
  output logic [NUM_CH-1:0] ovf,
  contador_param_if.slave   rd
);

  localparam int IDX_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] rd_clr;
  logic [CNT_W-1:0]  rd_val;
  logic              accept;
  logic              valid_q;
  logic [CNT_W-1:0]  data_q;

  assign accept = rd.req && (state == IDLE_ST);

  // One-hot channel select; an idx with no matching channel leaves sel
  // empty, so out-of-range reads naturally return zero and touch nothing.
  always_comb begin
    sel    = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i] = (rd.idx == IDX_W'(i));
      rd_val = rd_val | (cnt[i] & {CNT_W{sel[i]}});
    end
  end

`ifdef CONTADOR_CLR_ON_READ_EN
  assign rd_clr = sel & {NUM_CH{accept}};
`else
  assign rd_clr = '0;
`endif

  // Counters: global clr wins over everything; a destructive read restarts
  // the channel so a same-edge pop is still counted (leaves 1, ovf 0).
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_clr[i]) begin
          cnt[i] <= pop[i] ? CNT_W'(1) : '0;
          ovf[i] <= 1'b0;
        end else if (pop[i]) begin
          if (cnt[i] == CNT_MAX) begin
            ovf[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Response register samples the pre-update counter value, so data_out
  // never includes a pop or clear applied on the acceptance edge.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= accept;
      data_q  <= accept ? rd_val : '0;
    end
  end

  assign rd.valid    = valid_q;
  assign rd.data_out = data_q;

endmodule

// File: tb/tb_contador_param.sv
// tb/tb_contador_param.sv - self-checking bench for contador_param
module tb_contador_param;

  localparam logic [3:0] IDLE = 4'b0100;

  logic       clk;
  logic       reset_L;
  logic [3:0] state;
  logic [3:0] pop;
  logic       clr;
  logic [3:0] ovf;

  contador_param_if #(.NUM_CH(4), .CNT_W(5)) bus ();

  contador_param #(.NUM_CH(4), .CNT_W(5), .IDLE_ST(4'b0100)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .state   (state),
    .pop     (pop),
    .clr     (clr),
    .ovf     (ovf),
    .rd      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pop;
    logic [3:0] state;
    logic       req;
    logic [1:0] idx;
    logic       clr;
    logic       exp_valid;
    logic [4:0] exp_data;
  } vec_t;

  vec_t       vecs [15];
  logic [4:0] exp_q [$];
  int         passed;
  int         total;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] p, input logic [3:0] s, input logic r,
                       input logic [1:0] i, input logic c);
    pop     = p;
    state   = s;
    bus.req = r;
    bus.idx = i;
    clr     = c;
  endtask

  // One clock edge with the currently driven inputs; the expected response
  // is queued before the edge and retired from the queue after it.
  task automatic tick(input string name, input logic exp_v, input logic [4:0] exp_d);
    logic [4:0] d;
    if (exp_v) exp_q.push_back(exp_d);
    @(posedge clk);
    #1;
    chk({name, ".valid"}, int'(bus.valid), int'(exp_v));
    if (exp_v) begin
      if (exp_q.size() == 0) begin
        chk({name, ".queue"}, 0, 1);
      end else begin
        d = exp_q.pop_front();
        chk({name, ".data"}, int'(bus.data_out), int'(d));
      end
    end else begin
      chk({name, ".data_idle"}, int'(bus.data_out), 0);
    end
  endtask

  task automatic read_ch(input string name, input logic [1:0] i, input logic [4:0] exp_d);
    drive(4'b0000, IDLE, 1'b1, i, 1'b0);
    tick(name, 1'b1, exp_d);
  endtask

  task automatic idle_cycle(input string name);
    drive(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    tick(name, 1'b0, 5'd0);
  endtask

  initial begin
    passed = 0;
    total  = 0;

    vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0};
    vecs[1]  = '{4'b1110, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0};
    vecs[2]  = '{4'b1110, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0};
    vecs[3]  = '{4'b1110, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0};
    vecs[4]  = '{4'b1100, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0};
    vecs[5]  = '{4'b1100, 4'b1000, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0};
    vecs[6]  = '{4'b1100, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0};
    vecs[7]  = '{4'b1100, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0};
    vecs[8]  = '{4'b0000, IDLE,    1'b1, 2'd0, 1'b0, 1'b1, 5'd1};
    vecs[9]  = '{4'b0000, IDLE,    1'b1, 2'd1, 1'b0, 1'b1, 5'd4};
    vecs[10] = '{4'b0000, IDLE,    1'b1, 2'd2, 1'b0, 1'b1, 5'd8};
    vecs[11] = '{4'b0000, IDLE,    1'b1, 2'd3, 1'b0, 1'b1, 5'd8};
    vecs[12] = '{4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0};
    vecs[13] = '{4'b0000, IDLE,    1'b1, 2'd1, 1'b0, 1'b1, 5'd4};
    vecs[14] = '{4'b0000, IDLE,    1'b0, 2'd1, 1'b0, 1'b0, 5'd0};

    // Reset state, asserted asynchronously
    reset_L = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    #12;
    chk("rst.valid", int'(bus.valid), 0);
    chk("rst.data", int'(bus.data_out), 0);
    chk("rst.ovf", int'(ovf), 0);
    @(negedge clk);
    reset_L = 1'b1;

    // Counting, back-to-back reads and state gating
    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].pop, vecs[v].state, vecs[v].req, vecs[v].idx, vecs[v].clr);
      tick($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_data);
    end
    chk("vec.ovf", int'(ovf), 0);

    // Saturation and sticky ovf, then clear
    drive(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    tick("sat.clr0", 1'b0, 5'd0);
    for (int n = 0; n < 40; n++) begin
      drive(4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0);
      tick("sat.pop", 1'b0, 5'd0);
    end
    read_ch("sat.read", 2'd3, 5'd31);
    chk("sat.ovf", int'(ovf), 4'b1000);
    drive(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    tick("sat.clr", 1'b0, 5'd0);
    chk("sat.ovf_clr", int'(ovf), 0);
    read_ch("sat.read_clr", 2'd3, 5'd0);

    // clr + pop + read on one edge returns the pre-clear value
    for (int n = 0; n < 5; n++) begin
      drive(4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0);
      tick("sim.pop", 1'b0, 5'd0);
    end
    drive(4'b0100, IDLE, 1'b1, 2'd2, 1'b1);
    tick("sim.read", 1'b1, 5'd5);
    read_ch("sim.after", 2'd2, 5'd0);

    // Reset between acceptance and response
    for (int n = 0; n < 3; n++) begin
      drive(4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0);
      tick("rr.pop", 1'b0, 5'd0);
    end
    drive(4'b0000, IDLE, 1'b1, 2'd0, 1'b0);
    @(posedge clk);
    reset_L = 1'b0;
    #1;
    drive(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    chk("rr.valid", int'(bus.valid), 0);
    chk("rr.data", int'(bus.data_out), 0);
    @(negedge clk);
    chk("rr.valid_hold", int'(bus.valid), 0);
    reset_L = 1'b1;
    for (int c = 0; c < 4; c++) read_ch($sformatf("rr.read%0d", c), 2'(c), 5'd0);
    chk("rr.ovf", int'(ovf), 0);

    // Read-then-pop on the same edge; second read depends on read mode
    idle_cycle("cor.idle");
    for (int n = 0; n < 6; n++) begin
      drive(4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0);
      tick("cor.pop", 1'b0, 5'd0);
    end
    drive(4'b0010, IDLE, 1'b1, 2'd1, 1'b0);
    tick("cor.read1", 1'b1, 5'd6);
`ifdef CONTADOR_CLR_ON_READ_EN
    read_ch("cor.read2", 2'd1, 5'd1);
`else
    read_ch("cor.read2", 2'd1, 5'd7);
`endif
    idle_cycle("cor.end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
